// File: rtl/tmds_encoder_dvi.sv
// tmds_encoder_dvi: DVI 1.0 TMDS 8b/10b encoder for one colour channel, 2-cycle pipeline
module tmds_encoder_dvi (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       de,
    input  logic [7:0] din,
    input  logic [1:0] ctrl,
    output logic [9:0] tmds
);
    logic [3:0]        n1d, n1q;
    logic              use_xnor, bal_hit, same_sign;
    logic [8:0]        qm_d, qm;
    logic              de_q;
    logic [1:0]        ctrl_q;
    logic signed [5:0] cnt, bal, cnt_nx;
    logic [9:0]        tmds_nx, token;

    assign n1d      = 4'($countones(din));
    assign use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !din[0]);
    // Chained XNOR equals the running parity inverted on every odd bit.
    for (genvar i = 0; i < 8; i++) begin : g_qm
        assign qm_d[i] = (^din[i:0]) ^ (use_xnor && (i % 2 == 1));
    end
    assign qm_d[8] = !use_xnor;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            qm     <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
        end else begin
            qm     <= qm_d;
            de_q   <= de;
            ctrl_q <= ctrl;
        end
    end

    assign n1q       = 4'($countones(qm[7:0]));
    assign bal       = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    assign bal_hit   = cnt == 6'sd0 || bal == 6'sd0;
    assign same_sign = cnt[5] == bal[5];
    assign token     = ctrl_q == 2'b00 ? 10'h354 : ctrl_q == 2'b01 ? 10'h0AB :
                       ctrl_q == 2'b10 ? 10'h154 : 10'h2AB;

    always_comb begin
        tmds_nx = !de_q     ? token :
                  bal_hit   ? {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]} :
                  same_sign ? {1'b1, qm[8], ~qm[7:0]} :
                              {1'b0, qm[8], qm[7:0]};
        cnt_nx  = !de_q     ? 6'sd0 :
                  bal_hit   ? (qm[8] ? cnt + bal : cnt - bal) :
                  same_sign ? cnt + (qm[8] ? 6'sd2 : 6'sd0) - bal :
                              cnt + bal - (qm[8] ? 6'sd0 : 6'sd2);
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            tmds <= 10'h354;
            cnt  <= 6'sd0;
        end else begin
            tmds <= tmds_nx;
            cnt  <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// tb_tmds_encoder_dvi: scoreboard bench, random stimulus vs behavioural TMDS model and decoder
module tb_tmds_encoder_dvi;
  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b0;
  logic       de = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] ctrl = '0;
  logic [9:0] tmds;

  tmds_encoder_dvi dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .de(de),
    .din(din), .ctrl(ctrl), .tmds(tmds)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    int         due;
    logic [9:0] t;
    int         c;
    logic       de;
    logic [7:0] d;
    logic [1:0] k;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   errors = 0;
  int   m_cnt = 0;

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act == want) passed++;
    else begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc, act, act, want, want);
    end
  endtask

  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model(input logic d_e, input logic [7:0] d, input logic [1:0] k, output logic [9:0] t);
    logic [7:0] qm;
    logic       xnr, q8;
    int         n, diff;
    n   = ones(d);
    xnr = n > 4 || (n == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnr ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8   = !xnr;
    diff = 2 * ones(qm) - 8;
    if (!d_e) begin
      t = k == 2'b00 ? 10'h354 : k == 2'b01 ? 10'h0AB : k == 2'b10 ? 10'h154 : 10'h2AB;
      m_cnt = 0;
    end else if (m_cnt == 0 || diff == 0) begin
      t = {~q8, q8, q8 ? qm : ~qm};
      m_cnt += q8 ? diff : -diff;
    end else if ((m_cnt > 0 && diff > 0) || (m_cnt < 0 && diff < 0)) begin
      t = {1'b1, q8, ~qm};
      m_cnt += 2 * int'(q8) - diff;
    end else begin
      t = {1'b0, q8, qm};
      m_cnt += diff - 2 * int'(!q8);
    end
  endtask

  task automatic send(input logic d_e, input logic [7:0] d, input logic [1:0] k,
                      input bit fixed, input logic [9:0] ft, input int fc);
    exp_t       e;
    logic [9:0] t;
    de = d_e; din = d; ctrl = k;
    model(d_e, d, k, t);
    e.due = cyc + 2;
    e.t   = fixed ? ft : t;
    e.c   = fixed ? fc : m_cnt;
    e.de  = d_e; e.d = d; e.k = k;
    q.push_back(e);
    @(posedge clk_pix);
    #1;
  endtask

  task automatic pulse_reset();
    exp_t e;
    rst_pix = 1'b1;
    #1;
    chk("reset_tmds", int'(tmds), 'h354);
    chk("reset_cnt", int'($signed(dut.cnt)), 0);
    rst_pix = 1'b0;
    q.delete();
    m_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      e.due = cyc + i; e.t = 10'h354; e.c = 0; e.de = 1'b0; e.d = '0; e.k = 2'b00;
      q.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] dv, dec;
    logic [1:0] dk;
    bit         is_tok;
    int         c;
    forever begin
      @(negedge clk_pix);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          chk("missed_slot", e.due, cyc);
          continue;
        end
        c = int'($signed(dut.cnt));
        chk("tmds", int'(tmds), int'(e.t));
        chk("cnt", c, e.c);
        chk("cnt_even_bounded", int'(c % 2 == 0 && c >= -16 && c <= 16), 1);
        is_tok = 1'b1;
        case (tmds)
          10'h354: dk = 2'b00;
          10'h0AB: dk = 2'b01;
          10'h154: dk = 2'b10;
          10'h2AB: dk = 2'b11;
          default: begin dk = 2'b00; is_tok = 1'b0; end
        endcase
        dv = tmds[9] ? ~tmds[7:0] : tmds[7:0];
        dec[0] = dv[0];
        for (int i = 1; i < 8; i++) dec[i] = tmds[8] ? dv[i] ^ dv[i-1] : ~(dv[i] ^ dv[i-1]);
        if (e.de) chk("decode_data", is_tok ? -1 : int'(dec), int'(e.d));
        else      chk("decode_ctrl", is_tok ? int'(dk) : -1, int'(e.k));
      end
    end
  end

  initial begin : stimulus
    rst_pix = 1'b1;
    #1;
    chk("reset_async_tmds", int'(tmds), 'h354);
    @(posedge clk_pix);
    #1;
    pulse_reset();
    send(1'b0, 8'h00, 2'b00, 1'b0, '0, 0);
    send(1'b0, 8'h00, 2'b00, 1'b0, '0, 0);
    send(1'b0, 8'h5A, 2'b01, 1'b1, 10'h0AB, 0);
    send(1'b0, 8'hA5, 2'b10, 1'b1, 10'h154, 0);
    send(1'b0, 8'h3C, 2'b11, 1'b1, 10'h2AB, 0);
    send(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
    send(1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF, 2);
    send(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
    send(1'b1, 8'hFF, 2'b00, 1'b1, 10'h200, -8);
    for (int n = 0; n < 20000; n++) begin
      if (n % 1500 == 777) pulse_reset();
      send(($urandom % 8) != 0, 8'($urandom), 2'($urandom), 1'b0, '0, 0);
    end
    de = 1'b0;
    repeat (4) @(posedge clk_pix);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%s: %0d errors, %0d/%0d checks passed", errors == 0 ? "PASS" : "FAIL", errors, passed, checks);
    $finish;
  end
endmodule
